// File: rtl/mvu_pkg.sv
// Shared widths, defaults and job-sequencer state encoding for the MVU array.
package mvu_pkg;

    localparam int unsigned MVU_BWBANKA = 9;
    localparam int unsigned MVU_BDBANKA = 15;
    localparam int unsigned MVU_BPREC   = 6;
    localparam int unsigned MVU_BSTRIDE = 15;
    localparam int unsigned MVU_BLENGTH = 15;
    localparam int unsigned MVU_LAT     = 3;

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StDrain,
        StQuant,
        StFin
    } jobctl_state_e;

endpackage

// File: rtl/mvu_loopctr.sv
// Count-to-limit loop counter; wrap pulses on the increment that returns the count to zero.
module mvu_loopctr #(
    parameter int unsigned Width = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    input  logic [Width-1:0] limit,
    output logic [Width-1:0] count,
    output logic             wrap
);

    logic [Width-1:0] count_q, count_d;
    logic             at_last;

    assign at_last = (count_q == limit - Width'(1));
    assign wrap    = inc & at_last;
    assign count   = count_q;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc) begin
            count_d = at_last ? '0 : count_q + Width'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/mvu_jobctl.sv
// Per-MVU job sequencer: walks the output/weight-bit/input-bit/tile loop nest, issues reads,
// steers the accumulator and launches the quantizer once per output word.
module mvu_jobctl
    import mvu_pkg::*;
#(
    parameter int unsigned BWBANKA = MVU_BWBANKA,
    parameter int unsigned BDBANKA = MVU_BDBANKA,
    parameter int unsigned BPREC   = MVU_BPREC,
    parameter int unsigned BSTRIDE = MVU_BSTRIDE,
    parameter int unsigned BLENGTH = MVU_BLENGTH,
    parameter int unsigned LAT     = MVU_LAT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [BPREC-1:0]   wprecision,
    input  logic [BPREC-1:0]   iprecision,
    input  logic [BLENGTH-1:0] olength_0,
    input  logic [BLENGTH-1:0] ilength_0,
    input  logic [BWBANKA-1:0] wbaseaddr,
    input  logic [BDBANKA-1:0] ibaseaddr,
    input  logic [BSTRIDE-1:0] wstride_0,
    input  logic [BSTRIDE-1:0] wstride_1,
    input  logic [BSTRIDE-1:0] istride_0,
    input  logic               rdd_grnt,
    output logic               busy,
    output logic               done,
    output logic [BWBANKA-1:0] rdw_addr,
    output logic               rdd_en,
    output logic [BDBANKA-1:0] rdd_addr,
    output logic               acc_clr,
    output logic               acc_sh,
    output logic               quant_start
);

    localparam int unsigned DrainW = (LAT > 1) ? $clog2(LAT) : 1;

    jobctl_state_e state_q, state_d;

    // Shadow copies of the job configuration, captured on an accepted start.
    logic [BPREC-1:0]   wprec_q, iprec_q;
    logic [BLENGTH-1:0] olen_q, ilen_q;
    logic [BWBANKA-1:0] wbase_q;
    logic [BDBANKA-1:0] ibase_q;
    logic [BSTRIDE-1:0] wstr0_q, wstr1_q, istr0_q;

    logic [BWBANKA-1:0] wout_q, wout_d, rdw_q, rdw_d;
    logic [BDBANKA-1:0] rdd_q, rdd_d;
    logic [DrainW-1:0]  drain_q, drain_d;

    logic               load, fire, in_issue, in_quant, zero_job;
    logic               t_wrap, ib_wrap, wb_wrap, o_wrap;
    logic [BLENGTH-1:0] t_cnt, o_cnt;
    logic [BPREC-1:0]   ib_cnt, wb_cnt, ib_next, wb_next;

    assign in_issue = (state_q == StIssue);
    assign in_quant = (state_q == StQuant);
    assign load     = (state_q == StIdle) & start;
    assign fire     = in_issue & rdd_grnt;
    assign zero_job = (olength_0 == '0) | (ilength_0 == '0) | (wprecision == '0) |
                      (iprecision == '0);

    mvu_loopctr #(.Width(BLENGTH)) u_t_ctr (
        .clk   (clk),
        .rst   (rst),
        .clr   (load),
        .inc   (fire),
        .limit (ilen_q),
        .count (t_cnt),
        .wrap  (t_wrap)
    );

    mvu_loopctr #(.Width(BPREC)) u_ib_ctr (
        .clk   (clk),
        .rst   (rst),
        .clr   (load),
        .inc   (t_wrap),
        .limit (iprec_q),
        .count (ib_cnt),
        .wrap  (ib_wrap)
    );

    mvu_loopctr #(.Width(BPREC)) u_wb_ctr (
        .clk   (clk),
        .rst   (rst),
        .clr   (load),
        .inc   (ib_wrap),
        .limit (wprec_q),
        .count (wb_cnt),
        .wrap  (wb_wrap)
    );

    mvu_loopctr #(.Width(BLENGTH)) u_o_ctr (
        .clk   (clk),
        .rst   (rst),
        .clr   (load),
        .inc   (in_quant),
        .limit (olen_q),
        .count (o_cnt),
        .wrap  (o_wrap)
    );

    // Bit indices the loop nest moves to when the tile loop wraps.
    assign ib_next = ib_wrap ? '0 : ib_cnt + BPREC'(1);
    assign wb_next = wb_wrap ? '0 : (ib_wrap ? wb_cnt + BPREC'(1) : wb_cnt);

    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = zero_job ? StFin : StIssue;
                end
            end
            StIssue: begin
                if (wb_wrap) begin
                    state_d = StDrain;
                    drain_d = '0;
                end
            end
            StDrain: begin
                if (drain_q == DrainW'(LAT - 1)) begin
                    state_d = StQuant;
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end
            StQuant: state_d = o_wrap ? StFin : StIssue;
            StFin:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Running-sum address generation: stride steps within a tile walk, rebase on tile wrap.
    always_comb begin
        rdd_d  = rdd_q;
        rdw_d  = rdw_q;
        wout_d = wout_q;
        if (load) begin
            rdd_d  = ibaseaddr;
            rdw_d  = wbaseaddr;
            wout_d = wbaseaddr;
        end else if (fire) begin
            if (t_wrap) begin
                rdd_d = ibase_q + BDBANKA'(ib_next);
                rdw_d = wout_q + BWBANKA'(wb_next);
            end else begin
                rdd_d = rdd_q + BDBANKA'(istr0_q);
                rdw_d = rdw_q + BWBANKA'(wstr0_q);
            end
        end else if (in_quant) begin
            wout_d = wout_q + BWBANKA'(wstr1_q);
            rdw_d  = wout_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            drain_q <= '0;
            rdd_q   <= '0;
            rdw_q   <= '0;
            wout_q  <= '0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
            rdd_q   <= rdd_d;
            rdw_q   <= rdw_d;
            wout_q  <= wout_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wprec_q <= '0;
            iprec_q <= '0;
            olen_q  <= '0;
            ilen_q  <= '0;
            wbase_q <= '0;
            ibase_q <= '0;
            wstr0_q <= '0;
            wstr1_q <= '0;
            istr0_q <= '0;
        end else if (load) begin
            wprec_q <= wprecision;
            iprec_q <= iprecision;
            olen_q  <= olength_0;
            ilen_q  <= ilength_0;
            wbase_q <= wbaseaddr;
            ibase_q <= ibaseaddr;
            wstr0_q <= wstride_0;
            wstr1_q <= wstride_1;
            istr0_q <= istride_0;
        end
    end

    logic first_grp;
    assign first_grp = (ib_cnt == '0) & (wb_cnt == '0);

    assign busy        = (state_q != StIdle);
    assign done        = (state_q == StFin);
    assign rdd_en      = in_issue;
    assign quant_start = in_quant;
    assign rdd_addr    = rdd_q;
    assign rdw_addr    = rdw_q;
    assign acc_clr     = in_issue & (t_cnt == '0) & first_grp;
    assign acc_sh      = in_issue & (t_cnt == '0) & ~first_grp;

endmodule

// File: tb/tb_mvu_jobctl.sv
// Self-checking bench for mvu_jobctl: job table plus expected-read scoreboard and a reset sequence.
module tb_mvu_jobctl;

    localparam int unsigned BWBANKA = 9;
    localparam int unsigned BDBANKA = 15;
    localparam int unsigned BPREC   = 6;
    localparam int unsigned BSTRIDE = 15;
    localparam int unsigned BLENGTH = 15;
    localparam int unsigned LAT     = 3;
    localparam int          NJOBS   = 7;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic [BPREC-1:0]   wprecision, iprecision;
    logic [BLENGTH-1:0] olength_0, ilength_0;
    logic [BWBANKA-1:0] wbaseaddr;
    logic [BDBANKA-1:0] ibaseaddr;
    logic [BSTRIDE-1:0] wstride_0, wstride_1, istride_0;
    logic               rdd_grnt;
    logic               busy, done, rdd_en, acc_clr, acc_sh, quant_start;
    logic [BWBANKA-1:0] rdw_addr;
    logic [BDBANKA-1:0] rdd_addr;

    always #5 clk = ~clk;

    mvu_jobctl #(
        .BWBANKA (BWBANKA),
        .BDBANKA (BDBANKA),
        .BPREC   (BPREC),
        .BSTRIDE (BSTRIDE),
        .BLENGTH (BLENGTH),
        .LAT     (LAT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .wprecision  (wprecision),
        .iprecision  (iprecision),
        .olength_0   (olength_0),
        .ilength_0   (ilength_0),
        .wbaseaddr   (wbaseaddr),
        .ibaseaddr   (ibaseaddr),
        .wstride_0   (wstride_0),
        .wstride_1   (wstride_1),
        .istride_0   (istride_0),
        .rdd_grnt    (rdd_grnt),
        .busy        (busy),
        .done        (done),
        .rdw_addr    (rdw_addr),
        .rdd_en      (rdd_en),
        .rdd_addr    (rdd_addr),
        .acc_clr     (acc_clr),
        .acc_sh      (acc_sh),
        .quant_start (quant_start)
    );

    typedef struct {
        int o, t, wp, ip;
        int ibase, istr, wbase, ws0, ws1;
        int stall_at, stall_len, restart_at;
        int exp_done, exp_nq;
    } job_t;

    typedef struct {
        logic [BDBANKA-1:0] d;
        logic [BWBANKA-1:0] w;
        logic               clr, sh;
    } rd_t;

    job_t jobs[NJOBS];
    rd_t  exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic logic gnt_for(input job_t j, input int cyc);
        return !(j.stall_len > 0 && cyc >= j.stall_at && cyc < j.stall_at + j.stall_len);
    endfunction

    // Expected read stream straight from the address formulas of the loop nest.
    task automatic push_model(input job_t j);
        rd_t r;
        exp_q.delete();
        if (j.o == 0 || j.t == 0 || j.wp == 0 || j.ip == 0) return;
        for (int o = 0; o < j.o; o++)
            for (int wb = 0; wb < j.wp; wb++)
                for (int ib = 0; ib < j.ip; ib++)
                    for (int t = 0; t < j.t; t++) begin
                        r.d   = 15'((j.ibase + t * j.istr + ib) % 32768);
                        r.w   = 9'((j.wbase + o * j.ws1 + t * j.ws0 + wb) % 512);
                        r.clr = (wb == 0 && ib == 0 && t == 0);
                        r.sh  = (t == 0) && !(wb == 0 && ib == 0);
                        exp_q.push_back(r);
                    end
    endtask

    task automatic drive_cfg(input job_t j);
        olength_0  = BLENGTH'(j.o);
        ilength_0  = BLENGTH'(j.t);
        wprecision = BPREC'(j.wp);
        iprecision = BPREC'(j.ip);
        ibaseaddr  = BDBANKA'(j.ibase);
        istride_0  = BSTRIDE'(j.istr);
        wbaseaddr  = BWBANKA'(j.wbase);
        wstride_0  = BSTRIDE'(j.ws0);
        wstride_1  = BSTRIDE'(j.ws1);
    endtask

    task automatic run_job(input job_t j, input int id);
        int  cyc, nq, last_q, nreads, npush;
        bit  fin;
        rd_t e;
        push_model(j);
        npush = exp_q.size();
        @(negedge clk);
        drive_cfg(j);
        start    = 1'b1;
        rdd_grnt = gnt_for(j, 1);
        @(posedge clk);
        #1 start = 1'b0;
        cyc = 0; nq = 0; last_q = -1; nreads = 0; fin = 0;
        while (!fin && cyc < 500) begin
            @(negedge clk);
            cyc++;
            rdd_grnt = gnt_for(j, cyc);
            start    = (cyc == j.restart_at);
            if (start) begin
                // Busy-time start with scrambled config must leave the running job untouched.
                olength_0 = 7; ilength_0 = 5; ibaseaddr = 15'h1234; wbaseaddr = 9'h0AB;
                istride_0 = 99; wstride_0 = 33;
            end
            if (cyc == 1) check($sformatf("j%0d_busy_c1", id), busy, 1);
            if (rdd_en && exp_q.size() > 0) begin
                e = exp_q[0];
                check($sformatf("j%0d_rdd_addr_c%0d", id, cyc), rdd_addr, e.d);
                check($sformatf("j%0d_rdw_addr_c%0d", id, cyc), rdw_addr, e.w);
                check($sformatf("j%0d_acc_clr_c%0d", id, cyc), acc_clr, e.clr);
                check($sformatf("j%0d_acc_sh_c%0d", id, cyc), acc_sh, e.sh);
            end
            if (rdd_en && rdd_grnt) begin
                nreads++;
                if (exp_q.size() > 0) void'(exp_q.pop_front());
            end
            if (quant_start) begin
                nq++;
                last_q = cyc;
                check($sformatf("j%0d_quant_vs_en_c%0d", id, cyc), rdd_en, 0);
            end
            if (done) begin
                fin = 1;
                check($sformatf("j%0d_done_cycle", id), cyc, j.exp_done);
                check($sformatf("j%0d_quant_count", id), nq, j.exp_nq);
                check($sformatf("j%0d_last_quant", id), last_q,
                      (j.exp_nq > 0) ? j.exp_done - 1 : -1);
                check($sformatf("j%0d_read_count", id), nreads, npush);
            end
        end
        check($sformatf("j%0d_done_seen", id), fin, 1);
        @(negedge clk);
        start = 1'b0;
        check($sformatf("j%0d_busy_after_done", id), busy, 0);
        check($sformatf("j%0d_done_one_cycle", id), done, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_checks);
        $fatal(1);
    end

    initial begin
        int nd;
        //         o  t wp ip  ibase   istr wbase ws0 ws1 stA stL rst done nq
        jobs[0] = '{1, 2, 1, 1, 100,     4,  10,   2,  0,  0,  0,  0,  7, 1};
        jobs[1] = '{2, 1, 2, 2, 200,     3,  20,   5, 16,  0,  0,  0, 17, 2};
        jobs[2] = '{2, 3, 2, 1,  50,     7, 300,   3, 40,  3,  3,  5, 24, 2};
        jobs[3] = '{3, 0, 1, 1,  10,     1,   5,   1,  1,  0,  0,  1,  1, 0};
        jobs[4] = '{1, 3, 1, 1, 32766,   1, 510,   1,  0,  0,  0,  0,  8, 1};
        jobs[5] = '{2, 2, 0, 1,  10,     1,   5,   1,  1,  0,  0,  0,  1, 0};
        jobs[6] = '{1, 2, 2, 3, 1000,   10, 100,   9,  0,  0,  0,  0, 17, 1};

        rst = 1'b1; start = 1'b0; rdd_grnt = 1'b0;
        drive_cfg(jobs[0]);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rdd_en", rdd_en, 0);
        check("rst_rdd_addr", rdd_addr, 0);
        check("rst_rdw_addr", rdw_addr, 0);
        check("rst_acc_clr", acc_clr, 0);
        check("rst_acc_sh", acc_sh, 0);
        check("rst_quant", quant_start, 0);
        rst = 1'b0;

        for (int i = 0; i < NJOBS; i++) run_job(jobs[i], i);

        // Reset during ISSUE: immediate abort, no done pulse, then a clean rerun.
        @(negedge clk);
        drive_cfg(jobs[0]);
        start = 1'b1; rdd_grnt = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        check("mid_rst_pre_en", rdd_en, 1);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_rdd_en", rdd_en, 0);
        check("mid_rst_rdd_addr", rdd_addr, 0);
        check("mid_rst_rdw_addr", rdw_addr, 0);
        check("mid_rst_acc_clr", acc_clr, 0);
        @(negedge clk);
        rst = 1'b0;
        nd = 0;
        repeat (6) begin
            @(negedge clk);
            nd += int'(done);
        end
        check("mid_rst_no_done", nd, 0);
        check("mid_rst_idle", busy, 0);
        run_job(jobs[0], 10);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mvu_jobctl.md
# mvu_jobctl

Per-MVU job sequencer that drives one `mvu` instance through a bit-serial matrix-vector job. It walks the output/weight-bit/input-bit/tile loop nest, issues weight and data reads, arbitrates data reads through the bank grant, steers accumulator clear/shift, and launches the quantizer once per output word. One instance sits beside each entry of the MVU array in the top level and replaces the tied-off `rdw_addr`/`rdd_*` wiring.

## Interface
- BWBANKA, 9: weight bank address width
- BDBANKA, 15: data bank address width
- BPREC, 6: precision field width
- BSTRIDE, 15: stride field width
- BLENGTH, 15: length field width
- LAT, 3: cycles from the last granted read to accumulator-valid (DRAIN length), ≥1

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- start  in  1  job start pulse; ignored while busy
- wprecision, iprecision  in  BPREC  weight/input bit counts
- olength_0  in  BLENGTH  output words per job
- ilength_0  in  BLENGTH  input tiles per output
- wbaseaddr  in  BWBANKA  weight base address
- ibaseaddr  in  BDBANKA  input base address
- wstride_0, wstride_1  in  BSTRIDE  weight stride per tile, per output
- istride_0  in  BSTRIDE  input stride per tile
- rdd_grnt  in  1  data-bank read grant
- busy  out  1  job in progress
- done  out  1  one-cycle job-complete pulse
- rdw_addr  out  BWBANKA  weight read address
- rdd_en  out  1  data read request
- rdd_addr  out  BDBANKA  data read address
- acc_clr, acc_sh  out  1  accumulator controls for the current read
- quant_start  out  1  quantizer launch pulse

## Operation
- States are IDLE, ISSUE, DRAIN, QUANT, FIN.
- IDLE: `start` latches all configuration inputs into shadow registers. If the latched `olength_0`, `ilength_0`, `wprecision` or `iprecision` is 0, go to FIN with no reads issued. Otherwise go to ISSUE.
- Loop nest is o (outputs), then wb (`wprecision`), then ib (`iprecision`), then t (tiles, innermost). All loops count up from 0.
- Addresses:
  - rdd_addr = ibaseaddr + t·istride_0 + ib
  - rdw_addr = wbaseaddr + o·wstride_1 + t·wstride_0 + wb
  - Sums wrap modulo 2^width.
  - Addresses are generated with running-sum adders; no multipliers.
- ISSUE: rdd_en=1. A read is consumed only on a cycle with rdd_en & rdd_grnt.
  - While the grant is low, rdd_addr, rdw_addr, acc_clr and acc_sh hold their values.
  - acc_clr=1 on the first read of each output (wb=ib=t=0).
  - acc_sh=1 on the first read (t=0) of every (wb,ib) group except the first group of an output.
  - After the last read of an output is granted, go to DRAIN.
- DRAIN: LAT cycles with rdd_en=0, then go to QUANT.
- QUANT: quant_start=1 for one cycle. Then return to ISSUE if o < olength_0−1, otherwise go to FIN.
- FIN: done=1 for one cycle, then go to IDLE.
- busy=1 in every state except IDLE.
- `start` while busy is ignored. Configuration inputs may change mid-job without effect.
- Reset values: all outputs 0, state IDLE. Reset mid-job aborts immediately with no done pulse.

## Timing
- `start` sampled high at edge 0 → busy=1 and rdd_en=1 from cycle 1.
- With grant always high, one read per cycle; a job of R reads per output spends R+LAT+1 cycles per output.
- Grant low for k cycles adds k cycles, with no lost or duplicated reads.
- quant_start never overlaps rdd_en.
- done asserts in the cycle after the last quant_start. busy falls the cycle after done.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- State encoding, the BPREC/BSTRIDE/BLENGTH widths and the LAT default live in a shared `mvu_pkg` package, alongside the widths used by the top level.
- One sub-module, `mvu_loopctr`, is a reusable count-to-limit counter with a wrap flag. It is instanced four times (t, ib, wb, o).
- Address running sums stay in `mvu_jobctl`.

## Test plan
- Job o=1, t=2, wp=1, ip=1, grant=1, ibase=100, istride_0=4, wbase=10, wstride_0=2:
  - Reads at cycles 1–2 with rdd_addr 100, 104 and rdw_addr 10, 12.
  - acc_clr in cycle 1 only; acc_sh never asserted.
  - quant_start in cycle 6, done in cycle 7, busy low in cycle 8.
- Job o=2, t=1, wp=2, ip=2, wstride_1=16:
  - Reads per output in order (wb,ib) = 00, 01, 10, 11.
  - acc_sh on reads 2–4 of each output.
  - rdw_addr for the second output starts at wbase+16.
  - Two quant_start pulses.
- Grant held low for 3 cycles mid-job: addresses frozen, total reads unchanged, done delayed exactly 3 cycles.
- ilength_0=0: start → done one cycle later, no rdd_en. Second start while busy: ignored.
- rst asserted during ISSUE: next cycle all outputs 0, state IDLE, no done pulse. A fresh start then runs normally.
- Wrap check: ibase=0x7FFE, istride_0=1, t=3 → rdd_addr 0x7FFE, 0x7FFF, 0x0000.
